ov7670_cam_axil_regs: RTL

AXI4-Lite slave (responder) register bank for the OV7670 camera IP: terminates the S01_AXI port driven by the processor or master BFM and exposes four 32-bit control registers to the camera datapath. Supports independent AW/W arrival, byte strobes, single outstanding write and read, and SLVERR for out-of-range addresses. The bank is the target end of the register write/read-back traffic the IP's bench issues at offsets 0x0, 0x4, 0x8 and 0xC.

---
 rtl/ov7670_cam_axil_regs.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/ov7670_cam_axil_regs.sv
// AXI4-Lite register bank for the OV7670 camera IP.
// Four 32-bit control registers at word offsets 0x0..0xC. AW and W are each
// buffered in a one-entry holding slot and committed together. Only one write
// and one read may be outstanding. Addresses above 0xC get SLVERR.
module ov7670_cam_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg0_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg1_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg2_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg3_o,
  output logic [3:0]                      wr_pulse_o
);

  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic                          r_en;
  logic                          r_aw_full;
  logic                          r_w_full;
  logic [C_S_AXI_ADDR_WIDTH-1:0] r_aw_addr;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_w_data;
  logic [STRB_W-1:0]             r_w_strb;
  logic                          r_bvalid;
  logic [1:0]                    r_bresp;
  logic                          r_rvalid;
  logic [1:0]                    r_rresp;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_reg [4];
  logic [3:0]                    r_wr_pulse;

  logic       w_awready;
  logic       w_wready;
  logic       w_arready;
  logic       w_aw_hs;
  logic       w_w_hs;
  logic       w_ar_hs;
  logic       w_commit;
  logic       w_aw_in_range;
  logic       w_ar_in_range;
  logic [1:0] w_aw_idx;
  logic [1:0] w_ar_idx;
  logic       w_unused;

  // Readies depend only on flops, so no VALID-to-READY combinational path.
  assign w_awready = r_en & ~r_aw_full & ~r_bvalid;
  assign w_wready  = r_en & ~r_w_full  & ~r_bvalid;
  assign w_arready = r_en & ~r_rvalid;

  assign w_aw_hs  = S_AXI_AWVALID & w_awready;
  assign w_w_hs   = S_AXI_WVALID  & w_wready;
  assign w_ar_hs  = S_AXI_ARVALID & w_arready;
  assign w_commit = r_aw_full & r_w_full & ~r_bvalid;

  assign w_aw_in_range = (r_aw_addr[C_S_AXI_ADDR_WIDTH-1:4] == '0);
  assign w_ar_in_range = (S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:4] == '0);
  assign w_aw_idx      = r_aw_addr[3:2];
  assign w_ar_idx      = S_AXI_ARADDR[3:2];

  // Protection bits and byte offsets play no part in decode.
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, r_aw_addr[1:0], S_AXI_ARADDR[1:0]};

  // Hold off all handshakes until the first edge after reset release.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_en <= 1'b0;
    else        r_en <= 1'b1;
  end

  // Write channel: capture AW/W independently, commit when both held, then B response.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_aw_full  <= 1'b0;
      r_w_full   <= 1'b0;
      r_aw_addr  <= '0;
      r_w_data   <= '0;
      r_w_strb   <= '0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= '0;
      if (w_aw_hs) begin
        r_aw_addr <= S_AXI_AWADDR;
        r_aw_full <= 1'b1;
      end
      if (w_w_hs) begin
        r_w_data <= S_AXI_WDATA;
        r_w_strb <= S_AXI_WSTRB;
        r_w_full <= 1'b1;
      end
      if (w_commit) begin
        r_aw_full <= 1'b0;
        r_w_full  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_aw_in_range ? RESP_OKAY : RESP_SLVERR;
        if (w_aw_in_range) r_wr_pulse[w_aw_idx] <= 1'b1;
      end else if (r_bvalid && S_AXI_BREADY) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // Register array: byte-masked update on an in-range commit.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < 4; i++) r_reg[i] <= '0;
    end else if (w_commit && w_aw_in_range) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (r_w_strb[b]) r_reg[w_aw_idx][8*b +: 8] <= r_w_data[8*b +: 8];
      end
    end
  end

  // Read channel: sample the register on the AR handshake, hold until R handshake.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_ar_in_range ? r_reg[w_ar_idx] : '0;
      r_rresp  <= w_ar_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (r_rvalid && S_AXI_RREADY) begin
      r_rvalid <= 1'b0;
    end
  end

  assign S_AXI_AWREADY = w_awready;
  assign S_AXI_WREADY  = w_wready;
  assign S_AXI_ARREADY = w_arready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;
  assign reg0_o        = r_reg[0];
  assign reg1_o        = r_reg[1];
  assign reg2_o        = r_reg[2];
  assign reg3_o        = r_reg[3];
  assign wr_pulse_o    = r_wr_pulse;

endmodule
